// File: rtl/dp_memory_pkg.sv
// Shared types and helpers for the dual-port memory controller.
// Word-width helpers operate on a MAX_DW-bit container; callers size-cast in and out.
package dp_memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam int MAX_DW = 256;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] oldWord,
                                                     input logic [MAX_DW-1:0] newWord,
                                                     input logic [MAX_BE-1:0] be);
        logic [MAX_DW-1:0] merged;
        merged = oldWord;
        for (int b = 0; b < MAX_BE; b++) begin
            if (be[b]) merged[b*8 +: 8] = newWord[b*8 +: 8];
        end
        return merged;
    endfunction

    // Even parity per byte: the stored bit makes each 9-bit group have an even number of ones.
    function automatic logic [MAX_BE-1:0] byte_parity(input logic [MAX_DW-1:0] word);
        logic [MAX_BE-1:0] par;
        for (int b = 0; b < MAX_BE; b++) begin
            par[b] = ^word[b*8 +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/dp_memory_ctrl_clear_fsm.sv
// Clear engine: sweeps every address once after reset or an iClear pulse, holding oBusy meanwhile.
module dp_memory_clear_fsm
    import dp_memory_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     iClk,
    input  logic                     iReset_n,
    input  logic                     iClear,
    output logic                     oBusy,
    output logic                     oClrWrEn,
    output logic [ADDRESS_WIDTH-1:0] oClrAddr
);

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] count;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= ST_CLEAR;
            count <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Counter wraps to zero after the last address, ready for the next clear.
                    count <= count + ADDRESS_WIDTH'(1);
                    if (count == '1) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (iClear) begin
                        state <= ST_CLEAR;
                        count <= '0;
                    end
                end
            endcase
        end
    end

    assign oBusy    = (state == ST_CLEAR);
    assign oClrWrEn = oBusy;
    assign oClrAddr = count;

endmodule

// File: rtl/dp_memory_ctrl.sv
// Simple-dual-port memory with byte enables, RDW control, clear engine and 1/2-cycle read latency.
// Optional per-byte even parity storage and checking when MEM_PARITY_EN is defined.
module dp_memory_ctrl
    import dp_memory_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iChipSelect_n,
    input  logic                      iWrite_n,
    input  logic [ADDRESS_WIDTH-1:0]  iWrAddress,
    input  logic [DATA_WIDTH-1:0]     iData,
    input  logic [DATA_WIDTH/8-1:0]   iByteEnable,
    input  logic                      iRead_n,
    input  logic [ADDRESS_WIDTH-1:0]  iRdAddress,
    input  logic                      iClear,
    output logic [DATA_WIDTH-1:0]     oData,
    output logic                      oDataValid,
    output logic                      oBusy,
    output logic                      oParityErr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic                     busy;
    logic                     clrWrEn;
    logic [ADDRESS_WIDTH-1:0] clrAddr;

    dp_memory_clear_fsm #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) uClearFsm (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iClear   (iClear),
        .oBusy    (busy),
        .oClrWrEn (clrWrEn),
        .oClrAddr (clrAddr)
    );

    assign oBusy = busy;

    // A clear request wins over any same-cycle access.
    logic idle, wrAccept, rdAccept;
    assign idle     = ~busy & ~iClear;
    assign wrAccept = idle & ~iChipSelect_n & ~iWrite_n;
    assign rdAccept = idle & ~iChipSelect_n & ~iRead_n;

    logic                     memWrEn;
    logic [ADDRESS_WIDTH-1:0] memWrAddr;
    logic [DATA_WIDTH-1:0]    memWrData;
    logic [NB-1:0]            memWrBe;

    assign memWrEn   = clrWrEn | wrAccept;
    assign memWrAddr = clrWrEn ? clrAddr : iWrAddress;
    assign memWrData = clrWrEn ? '0 : iData;
    assign memWrBe   = clrWrEn ? '1 : iByteEnable;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (memWrEn) begin
            for (int b = 0; b < NB; b++) begin
                if (memWrBe[b]) mem[memWrAddr][b*8 +: 8] <= memWrData[b*8 +: 8];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rdOld, merged, rdWord;
    logic                  sameAddr, useMerged;

    assign rdOld     = mem[iRdAddress];
    assign merged    = DATA_WIDTH'(byte_merge(MAX_DW'(rdOld), MAX_DW'(iData), MAX_BE'(iByteEnable)));
    assign sameAddr  = wrAccept & (iWrAddress == iRdAddress);
    assign useMerged = (RDW_MODE == RDW_WRITE_FIRST) && sameAddr;
    assign rdWord    = useMerged ? merged : rdOld;

    logic rdErr;

`ifdef MEM_PARITY_EN
    logic [NB-1:0] parMem [DEPTH];
    logic [NB-1:0] memWrPar, parOld, parNew, parRd;

    // Cleared words hold zero data, whose even parity is zero as well.
    assign memWrPar = NB'(byte_parity(MAX_DW'(memWrData)));

    always_ff @(posedge iClk) begin
        if (memWrEn) begin
            for (int b = 0; b < NB; b++) begin
                if (memWrBe[b]) parMem[memWrAddr][b] <= memWrPar[b];
            end
        end
    end

    assign parOld = parMem[iRdAddress];
    assign parNew = NB'(byte_parity(MAX_DW'(iData)));
    assign parRd  = useMerged ? ((parNew & iByteEnable) | (parOld & ~iByteEnable)) : parOld;
    assign rdErr  = |(NB'(byte_parity(MAX_DW'(rdWord))) ^ parRd);
`else
    assign rdErr = 1'b0;
`endif

    generate
        if (READ_LATENCY == 2) begin : gLat2
            logic [DATA_WIDTH-1:0] data_p0;
            logic                  vld_p0;
            logic                  err_p0;

            // Stage p0: capture the array read.
            always_ff @(posedge iClk or negedge iReset_n) begin
                if (!iReset_n) begin
                    vld_p0  <= 1'b0;
                    err_p0  <= 1'b0;
                    data_p0 <= '0;
                end else begin
                    vld_p0 <= rdAccept;
                    if (rdAccept) begin
                        data_p0 <= rdWord;
                        err_p0  <= rdErr;
                    end
                end
            end

            // Stage p1: output register, data held between strobes.
            always_ff @(posedge iClk or negedge iReset_n) begin
                if (!iReset_n) begin
                    oDataValid <= 1'b0;
                    oParityErr <= 1'b0;
                    oData      <= '0;
                end else begin
                    oDataValid <= vld_p0;
                    oParityErr <= vld_p0 & err_p0;
                    if (vld_p0) oData <= data_p0;
                end
            end
        end else begin : gLat1
            // Stage p0: array read straight into the output register.
            always_ff @(posedge iClk or negedge iReset_n) begin
                if (!iReset_n) begin
                    oDataValid <= 1'b0;
                    oParityErr <= 1'b0;
                    oData      <= '0;
                end else begin
                    oDataValid <= rdAccept;
                    oParityErr <= rdAccept & rdErr;
                    if (rdAccept) oData <= rdWord;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dp_memory_ctrl.sv
// Directed bench: one read-first/latency-1 instance and one write-first/latency-2 instance share stimulus.
module tb_dp_memory_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n, wr_n, rd_n, clr;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] d;
    logic [3:0]    be;

    logic [DW-1:0] dataA, dataB;
    logic          vldA, vldB, busyA, busyB, perrA, perrB;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dp_memory_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0)) dutA (
        .iClk(clk), .iReset_n(rst_n), .iChipSelect_n(cs_n), .iWrite_n(wr_n),
        .iWrAddress(wa), .iData(d), .iByteEnable(be), .iRead_n(rd_n), .iRdAddress(ra),
        .iClear(clr), .oData(dataA), .oDataValid(vldA), .oBusy(busyA), .oParityErr(perrA)
    );

    dp_memory_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(1)) dutB (
        .iClk(clk), .iReset_n(rst_n), .iChipSelect_n(cs_n), .iWrite_n(wr_n),
        .iWrAddress(wa), .iData(d), .iByteEnable(be), .iRead_n(rd_n), .iRdAddress(ra),
        .iClear(clr), .oData(dataB), .oDataValid(vldB), .oBusy(busyB), .oParityErr(perrB)
    );

    typedef struct {
        logic          cs_n;
        logic          wr_n;
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
        logic [3:0]    be;
        logic          rd_n;
        logic [AW-1:0] ra;
        logic          vA;
        logic [DW-1:0] dA;
        logic          vB;
        logic [DW-1:0] dB;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic c, input logic w, input logic [AW-1:0] wad,
                                input logic [DW-1:0] dat, input logic [3:0] ben,
                                input logic r, input logic [AW-1:0] rad,
                                input logic va, input logic [DW-1:0] da,
                                input logic vb, input logic [DW-1:0] db);
        vec_t v;
        v.cs_n = c; v.wr_n = w; v.wa = wad; v.d = dat; v.be = ben;
        v.rd_n = r; v.ra = rad; v.vA = va; v.dA = da; v.vB = vb; v.dB = db;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idleIn();
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; clr = 1'b0;
        wa = '0; ra = '0; d = '0; be = '0;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] v);
        idleIn();
        cs_n = 1'b0; wr_n = 1'b0; wa = a; d = v; be = 4'hF;
        @(negedge clk);
        idleIn();
    endtask

    task automatic rdChk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        idleIn();
        cs_n = 1'b0; rd_n = 1'b0; ra = a;
        @(negedge clk);
        idleIn();
        chk({nm, ".vldA"}, 32'(vldA), 32'd1);
        chk({nm, ".dataA"}, dataA, exp);
        @(negedge clk);
        chk({nm, ".vldB"}, 32'(vldB), 32'd1);
        chk({nm, ".dataB"}, dataB, exp);
    endtask

    // Counts negedges with oBusy high; optionally fires requests at the memory meanwhile.
    task automatic waitBusy(input bit junk, output int n, output int spur);
        n = 0;
        spur = 0;
        while (busyA === 1'b1 && n < 100) begin
            if (n > 0 && (vldA === 1'b1 || vldB === 1'b1)) spur++;
            n++;
            idleIn();
            if (junk) begin
                cs_n = 1'b0; rd_n = 1'b0; ra = 4'd3;
                if (n >= 14) begin wr_n = 1'b0; wa = 4'd0; d = 32'h77777777; be = 4'hF; end
            end
            @(negedge clk);
        end
        idleIn();
    endtask

    task automatic corruptParity();
`ifdef MEM_PARITY_EN
        dutB.parMem[2][0] = ~dutB.parMem[2][0];
`endif
    endtask

    int n, spur;
    logic expPerr;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MEM_PARITY_EN
        expPerr = 1'b1;
`else
        expPerr = 1'b0;
`endif
        tbl[0]  = mk(0, 0, 3,  32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 0, 3,  32'h11112222, 4'h3, 1, 0, 0, 32'h0,        0, 32'h0);
        tbl[2]  = mk(0, 1, 0,  32'h0,        4'h0, 0, 3, 1, 32'hDEAD2222, 0, 32'h0);
        tbl[3]  = mk(0, 0, 5,  32'h12345678, 4'hF, 1, 0, 0, 32'hDEAD2222, 1, 32'hDEAD2222);
        tbl[4]  = mk(0, 0, 5,  32'hAAAA5555, 4'hF, 0, 5, 1, 32'h12345678, 0, 32'hDEAD2222);
        tbl[5]  = mk(0, 1, 0,  32'h0,        4'h0, 1, 0, 0, 32'h12345678, 1, 32'hAAAA5555);
        tbl[6]  = mk(0, 1, 0,  32'h0,        4'h0, 0, 5, 1, 32'hAAAA5555, 0, 32'hAAAA5555);
        tbl[7]  = mk(1, 0, 6,  32'h55555555, 4'hF, 0, 5, 0, 32'hAAAA5555, 1, 32'hAAAA5555);
        tbl[8]  = mk(0, 1, 0,  32'h0,        4'h0, 0, 6, 1, 32'h0,        0, 32'hAAAA5555);
        tbl[9]  = mk(0, 0, 7,  32'hFFFFFFFF, 4'h0, 0, 3, 1, 32'hDEAD2222, 1, 32'h0);
        tbl[10] = mk(0, 1, 0,  32'h0,        4'h0, 0, 7, 1, 32'h0,        1, 32'hDEAD2222);
        tbl[11] = mk(0, 0, 7,  32'hCAFEF00D, 4'hA, 0, 7, 1, 32'h0,        1, 32'h0);
        tbl[12] = mk(0, 1, 0,  32'h0,        4'h0, 1, 0, 0, 32'h0,        1, 32'hCA00F000);
        tbl[13] = mk(0, 1, 0,  32'h0,        4'h0, 0, 7, 1, 32'hCA00F000, 0, 32'hCA00F000);
        tbl[14] = mk(0, 1, 0,  32'h0,        4'h0, 1, 0, 0, 32'hCA00F000, 1, 32'hCA00F000);
        tbl[15] = mk(0, 0, 15, 32'h0F0F0F0F, 4'hF, 1, 0, 0, 32'hCA00F000, 0, 32'hCA00F000);
        tbl[16] = mk(0, 1, 0,  32'h0,        4'h0, 0, 15, 1, 32'h0F0F0F0F, 0, 32'hCA00F000);
        tbl[17] = mk(0, 1, 0,  32'h0,        4'h0, 1, 0, 0, 32'h0F0F0F0F, 1, 32'h0F0F0F0F);

        idleIn();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.vldA", 32'(vldA), 32'd0);
        chk("rst.dataA", dataA, 32'h0);
        chk("rst.busyA", 32'(busyA), 32'd1);
        chk("rst.vldB", 32'(vldB), 32'd0);
        chk("rst.dataB", dataB, 32'h0);
        chk("rst.busyB", 32'(busyB), 32'd1);

        // Initial clear after reset release, then every word reads back as zero.
        rst_n = 1'b1;
        waitBusy(1'b0, n, spur);
        chk("init.busyCycles", 32'(n), 32'd16);
        chk("init.spurious", 32'(spur), 32'd0);
        chk("init.busyB", 32'(busyB), 32'd0);
        for (int i = 0; i <= 16; i++) begin
            idleIn();
            if (i < 16) begin cs_n = 1'b0; rd_n = 1'b0; ra = AW'(i); end
            @(negedge clk);
            if (i < 16) begin
                chk($sformatf("init.rd%0d.vldA", i), 32'(vldA), 32'd1);
                chk($sformatf("init.rd%0d.dataA", i), dataA, 32'h0);
            end
            if (i >= 1) begin
                chk($sformatf("init.rd%0d.vldB", i - 1), 32'(vldB), 32'd1);
                chk($sformatf("init.rd%0d.dataB", i - 1), dataB, 32'h0);
            end
        end

        for (int i = 0; i < 18; i++) begin
            idleIn();
            cs_n = tbl[i].cs_n; wr_n = tbl[i].wr_n; wa = tbl[i].wa; d = tbl[i].d;
            be = tbl[i].be; rd_n = tbl[i].rd_n; ra = tbl[i].ra;
            @(negedge clk);
            chk($sformatf("vec%0d.vldA", i), 32'(vldA), 32'(tbl[i].vA));
            chk($sformatf("vec%0d.dataA", i), dataA, tbl[i].dA);
            chk($sformatf("vec%0d.vldB", i), 32'(vldB), 32'(tbl[i].vB));
            chk($sformatf("vec%0d.dataB", i), dataB, tbl[i].dB);
            chk($sformatf("vec%0d.perr", i), 32'({perrA, perrB}), 32'd0);
        end
        idleIn();
        @(negedge clk);

        // Read in flight when iClear arrives completes; the read alongside iClear is dropped.
        cs_n = 1'b0; rd_n = 1'b0; ra = 4'd3;
        @(negedge clk);
        chk("clr.pre.vldA", 32'(vldA), 32'd1);
        chk("clr.pre.dataA", dataA, 32'hDEAD2222);
        idleIn();
        clr = 1'b1; cs_n = 1'b0; rd_n = 1'b0; ra = 4'd2;
        @(negedge clk);
        idleIn();
        chk("clr.drop.vldA", 32'(vldA), 32'd0);
        chk("clr.busyA", 32'(busyA), 32'd1);
        chk("clr.inflight.vldB", 32'(vldB), 32'd1);
        chk("clr.inflight.dataB", dataB, 32'hDEAD2222);
        waitBusy(1'b1, n, spur);
        chk("clr.busyCycles", 32'(n), 32'd16);
        chk("clr.spurious", 32'(spur), 32'd0);
        chk("clr.exit.vldA", 32'(vldA), 32'd0);
        @(negedge clk);
        chk("clr.exit.vldB", 32'(vldB), 32'd0);
        rdChk("clr.rd3", 4'd3, 32'h0);
        rdChk("clr.rd0", 4'd0, 32'h0);
        rdChk("clr.rd15", 4'd15, 32'h0);

        // Reset in the middle of a clear restarts the sweep from address 0.
        doWrite(4'd9, 32'h9999AAAA);
        rdChk("mid.rd9", 4'd9, 32'h9999AAAA);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid.rst.dataA", dataA, 32'h0);
        chk("mid.rst.vldA", 32'(vldA), 32'd0);
        chk("mid.rst.dataB", dataB, 32'h0);
        chk("mid.rst.busyA", 32'(busyA), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        waitBusy(1'b0, n, spur);
        chk("mid.busyCycles", 32'(n), 32'd16);
        rdChk("mid.rd9.after", 4'd9, 32'h0);

        // Back-to-back reads; parity of word 2 is corrupted in the latency-2 instance.
        doWrite(4'd1, 32'h00000001);
        doWrite(4'd2, 32'h22224444);
        doWrite(4'd3, 32'h8000FFFF);
        corruptParity();
        for (int i = 0; i < 5; i++) begin
            idleIn();
            if (i < 3) begin cs_n = 1'b0; rd_n = 1'b0; ra = AW'(i + 1); end
            @(negedge clk);
            case (i)
                0: begin
                    chk("b2b.s1.dataA", dataA, 32'h00000001);
                    chk("b2b.s1.vldB", 32'(vldB), 32'd0);
                end
                1: begin
                    chk("b2b.s2.dataA", dataA, 32'h22224444);
                    chk("b2b.s1.vldB", 32'(vldB), 32'd1);
                    chk("b2b.s1.dataB", dataB, 32'h00000001);
                    chk("b2b.s1.perrB", 32'(perrB), 32'd0);
                end
                2: begin
                    chk("b2b.s3.vldA", 32'(vldA), 32'd1);
                    chk("b2b.s3.dataA", dataA, 32'h8000FFFF);
                    chk("b2b.s2.vldB", 32'(vldB), 32'd1);
                    chk("b2b.s2.dataB", dataB, 32'h22224444);
                    chk("b2b.s2.perrB", 32'(perrB), 32'(expPerr));
                    chk("b2b.s2.perrA", 32'(perrA), 32'd0);
                end
                3: begin
                    chk("b2b.end.vldA", 32'(vldA), 32'd0);
                    chk("b2b.s3.vldB", 32'(vldB), 32'd1);
                    chk("b2b.s3.dataB", dataB, 32'h8000FFFF);
                    chk("b2b.s3.perrB", 32'(perrB), 32'd0);
                end
                default: begin
                    chk("b2b.end.vldB", 32'(vldB), 32'd0);
                    chk("b2b.end.perrB", 32'(perrB), 32'd0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_memory_ctrl.md
Name: dp_memory_ctrl

Overview:
Parametrised simple-dual-port synchronous memory with one write port and one read port.
Adds per-byte write enables, selectable read latency, defined read-during-write behaviour and a hardware clear engine, so contents are zero after every reset.
Used as register-file / scratch storage behind a bus slave; the chip select gates both ports.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDRESS_WIDTH, 4, address bits; depth = 2**ADDRESS_WIDTH words.
READ_LATENCY, 1, cycles from accepted read to oDataValid; legal values 1 or 2.
RDW_MODE, 0, same-address read/write in one cycle: 0 = old data (read-first), 1 = new merged data (write-first).

Ports:
iClk  in  1  clock, rising edge.
iReset_n  in  1  asynchronous, active-low reset.
iChipSelect_n  in  1  active-low select; both ports are ignored when high.
iWrite_n  in  1  active-low write request.
iWrAddress  in  ADDRESS_WIDTH  write address.
iData  in  DATA_WIDTH  write data.
iByteEnable  in  DATA_WIDTH/8  per-byte write enable, active-high.
iRead_n  in  1  active-low read request.
iRdAddress  in  ADDRESS_WIDTH  read address.
iClear  in  1  single-cycle pulse; starts a full clear when idle.
oData  out  DATA_WIDTH  read data, held until the next valid read.
oDataValid  out  1  one-cycle strobe; oData is valid in the same cycle.
oBusy  out  1  high while the clear engine runs; all requests are dropped.
oParityErr  out  1  parity error flag, aligned with oDataValid (see Optional Feature).

Behaviour:
- FSM states: CLEAR, IDLE.
  - Asynchronous reset forces CLEAR, clear counter = 0, oData = 0, oDataValid = 0, oParityErr = 0, and flushes the read pipeline.
  - oBusy = 1 during reset and throughout CLEAR.
- CLEAR: writes word 0 to address = counter each cycle, counter +1. After the write to address 2**ADDRESS_WIDTH-1, go to IDLE.
  - Clear takes exactly 2**ADDRESS_WIDTH cycles; oBusy falls in the first IDLE cycle.
- IDLE:
  - iClear=1 -> CLEAR with counter = 0.
  - iClear has priority over a write or read in the same cycle; that request is dropped.
- Reset asserted mid-clear: the clear restarts from address 0 after reset release.
- Write accept: IDLE & ~iChipSelect_n & ~iWrite_n. On the clock edge, byte b is updated iff iByteEnable[b]=1. An all-zero byte enable is a no-op.
- Read accept: IDLE & ~iChipSelect_n & ~iRead_n.
  - READ_LATENCY=1: oData and oDataValid update at the accept edge (valid in the cycle after the request).
  - READ_LATENCY=2: one extra output register stage is added.
  - Back-to-back reads give one result per cycle.
  - A read accepted before iClear completes normally through the pipeline; oData keeps its last value otherwise.
- Read-during-write at the same address in one accept cycle:
  - RDW_MODE=0 returns pre-write data.
  - RDW_MODE=1 returns the byte-merged result (enabled bytes from iData, others from the old word).
- Different addresses: independent, both complete.
- Requests in CLEAR or while iChipSelect_n=1 are silently discarded and produce no oDataValid.

Optional Feature:
Macro MEM_PARITY_EN.
- Defined:
  - Memory stores one even-parity bit per byte, computed on write from the written bytes. The clear engine writes parity 0.
  - On read, parity is recomputed; oParityErr = 1 with oDataValid if any byte mismatches.
  - Hidden test hook: parameter-free force task in the bench corrupts a stored parity bit via hierarchical access.
- Not defined: no parity storage; oParityErr is constant 0.

Decomposition:
- Package dp_memory_pkg holds:
  - FSM state enum (ST_CLEAR, ST_IDLE);
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants;
  - function byte_merge(old, new, be);
  - function byte_parity(word).
- One sub-module, dp_memory_clear_fsm: owns the state, counter and oBusy, and outputs the clear write address/enable.
- The top level holds the array, port muxing, RDW logic and read pipeline.

Test Plan:
1. Reset release, DW=32, AW=4 -> oBusy high 16 cycles then low; reads of addresses 0..15 return 0x00000000 with oDataValid pulses.
2. Write 0xDEADBEEF @3 BE=4'b1111, then BE=4'b0011 data 0x11112222 @3, read @3 -> 0xDEAD2222 after READ_LATENCY cycles.
3. Same-cycle write 0xAAAA5555 @5 and read @5 (old 0x12345678): RDW_MODE=0 -> 0x12345678; RDW_MODE=1 -> 0xAAAA5555.
4. iClear pulse with a simultaneous read @2 -> read dropped (no oDataValid); oBusy for 16 cycles; all words read 0 afterwards.
5. iReset_n low at clear cycle 7, released -> full 16-cycle clear again; oData=0 and oDataValid=0 during reset.
6. Reads @1,@2,@3 on consecutive cycles with READ_LATENCY=2 -> three consecutive valid strobes with correct data. With MEM_PARITY_EN and a corrupted parity bit @2, oParityErr=1 only on the second strobe.
